// File: rtl/pipe_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_barrel_shifter
//  Purpose  : L-stage pipelined LSL/LSR/ASR/ROR barrel shifter, valid/ready.
//             Optional out_carry port under macro PIPE_BARREL_SHIFTER_CARRY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_barrel_shifter #(
   parameter int N = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_amt,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data
`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
   ,
   output logic                 out_carry
`endif
);

   localparam int L = $clog2(N);

   localparam logic [1:0] C_LSL = 2'b00;
   localparam logic [1:0] C_LSR = 2'b01;
   localparam logic [1:0] C_ASR = 2'b10;

   if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_width
      $error("pipe_barrel_shifter: N must be a power of two and at least 4");
   end

   // Whole-pipe stall: nothing moves unless the output slot is free.
   logic w_advance;
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   for (genvar k = 0; k < L; k++) begin : g_stage
      localparam int SH = 1 << k;

      logic         w_src_valid;
      logic [N-1:0] w_src_data;
      logic [L-1:0] w_src_amt;
      logic [1:0]   w_src_mode;
      logic [N-1:0] w_shifted;

      logic         r_valid;
      logic [N-1:0] r_data;
      logic [L-1:0] r_amt;
      logic [1:0]   r_mode;

`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
      logic w_src_carry;
      logic w_carry;
      logic r_carry;
`endif

      if (k == 0) begin : g_head
         assign w_src_valid = in_valid;
         assign w_src_data  = in_data;
         assign w_src_amt   = in_amt;
         assign w_src_mode  = in_mode;
`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
         assign w_src_carry = 1'b0;
`endif
      end else begin : g_body
         assign w_src_valid = g_stage[k-1].r_valid;
         assign w_src_data  = g_stage[k-1].r_data;
         assign w_src_amt   = g_stage[k-1].r_amt;
         assign w_src_mode  = g_stage[k-1].r_mode;
`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
         assign w_src_carry = g_stage[k-1].r_carry;
`endif
      end

      // Amount bits are consumed LSB-first; bit 0 here is amt bit k.
      always_comb begin
         w_shifted = w_src_data;
         if (w_src_amt[0]) begin
            case (w_src_mode)
               C_LSL:   w_shifted = w_src_data << SH;
               C_LSR:   w_shifted = w_src_data >> SH;
               C_ASR:   w_shifted = $signed(w_src_data) >>> SH;
               default: w_shifted = (w_src_data >> SH) | (w_src_data << (N - SH));
            endcase
         end
      end

`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
      // Right shifts and rotate all drop bit SH-1 last; LSL drops bit N-SH last.
      always_comb begin
         w_carry = w_src_carry;
         if (w_src_amt[0]) begin
            if (w_src_mode == C_LSL) begin
               w_carry = w_src_data[N-SH];
            end else begin
               w_carry = w_src_data[SH-1];
            end
         end
      end
`endif

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= '0;
`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
            r_carry <= 1'b0;
`endif
         end else if (w_advance) begin
            r_valid <= w_src_valid;
            r_data  <= w_shifted;
            r_amt   <= {1'b0, w_src_amt[L-1:1]};
            r_mode  <= w_src_mode;
`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
            r_carry <= w_carry;
`endif
         end
      end
   end

   assign out_valid = g_stage[L-1].r_valid;
   assign out_data  = g_stage[L-1].r_data;
`ifdef PIPE_BARREL_SHIFTER_CARRY_EN
   assign out_carry = g_stage[L-1].r_carry;
`endif

   logic w_unused;
   assign w_unused = ^{g_stage[L-1].r_amt, g_stage[L-1].r_mode};

endmodule
`default_nettype wire
